mem_arbiter: RTL and testbench

Sequences and shares the single-port RAM between the instruction-cache fill path and the data-cache read/write path. Each grant covers one word transaction. Grants are registered, and the dcache has priority. A starvation counter guarantees forward progress for instruction fetch. The block sits between both caches and the RAM model, in place of direct cache-to-RAM wiring.

---
 rtl/mem_arbiter.sv | 94 +++++++++
 tb/tb_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between icache fill and dcache read/write,
// with dcache priority and a starvation bound that guarantees instruction fetch progress.
module mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic [1:0]        owner
);
    typedef enum logic [1:0] {IDLE = 2'd0, SERVE_I = 2'd1, SERVE_D = 2'd2} state_t;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    state_t           state;
    logic [CNT_W-1:0] starveCnt;
    logic             dReq;
    logic             ramAccess;
    logic             goD;
    logic             servI;
    logic             servD;

    assign dReq      = dREN | dWEN;
    assign ramAccess = ramstate == ACCESS;
    assign goD       = dReq && (!iREN || starveCnt < CNT_MAX);
    assign servI     = state == SERVE_I;
    assign servD     = state == SERVE_D;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            starveCnt <= '0;
            owner     <= 2'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (goD) begin
                        state     <= SERVE_D;
                        owner     <= 2'd2;
                        // goD with iREN implies starveCnt < CNT_MAX, so the increment saturates naturally
                        starveCnt <= iREN ? starveCnt + 1'b1 : '0;
                    end else if (iREN) begin
                        state     <= SERVE_I;
                        owner     <= 2'd1;
                        starveCnt <= '0;
                    end
                end
                SERVE_I: begin
                    if (ramAccess || !iREN) begin
                        state <= IDLE;
                        owner <= 2'd0;
                    end
                end
                SERVE_D: begin
                    if (ramAccess || !dReq) begin
                        state <= IDLE;
                        owner <= 2'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    owner <= 2'd0;
                end
            endcase
        end
    end

    assign ramWEN   = servD && dWEN;
    assign ramREN   = servI || (servD && !dWEN);
    assign ramaddr  = servI ? iaddr : servD ? daddr : '0;
    assign ramstore = ramWEN ? dstore : '0;
    assign iwait    = !(servI && ramAccess);
    assign dwait    = !(servD && ramAccess);
    assign iload    = servI ? ramload : '0;
    assign dload    = servD ? ramload : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenario tasks plus a randomized run checked against a cycle-level reference model.
module tb_mem_arbiter;
    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic [1:0]  owner;
    int          checks = 0;
    int          errors = 0;

    mem_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .owner(owner)
    );

    always #5 CLK = ~CLK;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs;
        iREN = 0; dREN = 0; dWEN = 0; ramstate = 2'd0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0;
    endtask

    task automatic test_reset;
        clear_inputs();
        nRST = 0; iREN = 1; dREN = 1;
        #2;
        checks++;
        if ({ramREN, ramWEN, iwait, dwait, owner} !== 6'b001100) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 001100", {ramREN, ramWEN, iwait, dwait, owner});
        end
        checks++;
        if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: got addr=%0h store=%0h expected 0/0", ramaddr, ramstore);
        end
        tick();
        nRST = 1;
        tick();
        checks++;
        if (owner !== 2'd2) begin
            errors++;
            $display("FAIL reset_release_owner: got %0d expected 2", owner);
        end
        nRST = 0;
        #1;
        checks++;
        if (ramREN !== 1'b0 || owner !== 2'd0 || dwait !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got ramREN=%b owner=%0d dwait=%b expected 0/0/1", ramREN, owner, dwait);
        end
        clear_inputs();
        nRST = 1;
        tick();
    endtask

    task automatic test_ifetch;
        iREN = 1; iaddr = 32'h40; ramstate = 2'd1;
        #1;
        checks++;
        if (owner !== 2'd0 || ramREN !== 1'b0) begin
            errors++;
            $display("FAIL ifetch_arb: got owner=%0d ramREN=%b expected 0/0", owner, ramREN);
        end
        for (int c = 1; c <= 3; c++) begin
            tick();
            if (c == 3) begin
                ramstate = 2'd2;
                ramload = 32'hDEADBEEF;
            end
            #1;
            checks++;
            if (ramaddr !== 32'h40 || ramREN !== 1'b1 || iwait !== (c != 3)) begin
                errors++;
                $display("FAIL ifetch_cycle%0d: got addr=%0h ren=%b iwait=%b expected 40/1/%b", c, ramaddr, ramREN, iwait, c != 3);
            end
        end
        checks++;
        if (iload !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL ifetch_load: got %0h expected deadbeef", iload);
        end
        tick();
        checks++;
        if (owner !== 2'd0) begin
            errors++;
            $display("FAIL ifetch_done: got owner=%0d expected 0", owner);
        end
        clear_inputs();
    endtask

    task automatic test_simultaneous;
        iREN = 1; dREN = 1; daddr = 32'h100; iaddr = 32'h200; ramstate = 2'd0;
        tick();
        checks++;
        if (owner !== 2'd2 || ramaddr !== 32'h100 || iwait !== 1'b1) begin
            errors++;
            $display("FAIL simul_dfirst: got owner=%0d addr=%0h iwait=%b expected 2/100/1", owner, ramaddr, iwait);
        end
        ramstate = 2'd2; ramload = 32'hCAFE0001;
        #1;
        checks++;
        if (dwait !== 1'b0 || dload !== 32'hCAFE0001 || iload !== 32'h0) begin
            errors++;
            $display("FAIL simul_daccess: got dwait=%b dload=%0h iload=%0h expected 0/cafe0001/0", dwait, dload, iload);
        end
        tick();
        dREN = 0; ramstate = 2'd0;
        #1;
        checks++;
        if (owner !== 2'd0 || ramREN !== 1'b0) begin
            errors++;
            $display("FAIL simul_idle: got owner=%0d ramREN=%b expected 0/0", owner, ramREN);
        end
        tick();
        checks++;
        if (owner !== 2'd1 || ramaddr !== 32'h200) begin
            errors++;
            $display("FAIL simul_ithen: got owner=%0d addr=%0h expected 1/200", owner, ramaddr);
        end
        ramstate = 2'd2;
        tick();
        clear_inputs();
    endtask

    task automatic test_starvation;
        logic [1:0] seq [11] = '{2, 0, 2, 0, 2, 0, 2, 0, 1, 0, 2};
        dWEN = 1; iREN = 1; daddr = 32'h500; dstore = 32'h77; iaddr = 32'h300; ramstate = 2'd2;
        for (int c = 0; c < 11; c++) begin
            tick();
            checks++;
            if (owner !== seq[c]) begin
                errors++;
                $display("FAIL starve_seq%0d: got owner=%0d expected %0d", c, owner, seq[c]);
            end
            if (c == 8) begin
                checks++;
                if (ramaddr !== 32'h300 || ramWEN !== 1'b0) begin
                    errors++;
                    $display("FAIL starve_iaddr: got addr=%0h wen=%b expected 300/0", ramaddr, ramWEN);
                end
            end
        end
        clear_inputs();
        ramstate = 2'd2;
        tick();
        clear_inputs();
    endtask

    task automatic test_write_priority;
        dREN = 1; dWEN = 1; daddr = 32'h8; dstore = 32'h1234; ramstate = 2'd1;
        tick();
        checks++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h1234 || ramaddr !== 32'h8 || dwait !== 1'b1) begin
            errors++;
            $display("FAIL wpri_busy: got wen=%b ren=%b store=%0h addr=%0h dwait=%b expected 1/0/1234/8/1",
                     ramWEN, ramREN, ramstore, ramaddr, dwait);
        end
        ramstate = 2'd2;
        #1;
        checks++;
        if (dwait !== 1'b0) begin
            errors++;
            $display("FAIL wpri_access: got dwait=%b expected 0", dwait);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (owner !== 2'd0) begin
            errors++;
            $display("FAIL wpri_done: got owner=%0d expected 0", owner);
        end
    endtask

    task automatic test_abort_error;
        iREN = 1; iaddr = 32'h80; ramstate = 2'd3;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (owner !== 2'd1 || iwait !== 1'b1 || ramREN !== 1'b1) begin
                errors++;
                $display("FAIL error_hold%0d: got owner=%0d iwait=%b ren=%b expected 1/1/1", c, owner, iwait, ramREN);
            end
        end
        iREN = 0;
        #1;
        checks++;
        if (iwait !== 1'b1) begin
            errors++;
            $display("FAIL abort_nopulse: got iwait=%b expected 1", iwait);
        end
        tick();
        checks++;
        if (owner !== 2'd0 || iwait !== 1'b1) begin
            errors++;
            $display("FAIL abort_idle: got owner=%0d iwait=%b expected 0/1", owner, iwait);
        end
        clear_inputs();
    endtask

    task automatic test_random;
        int mOwner = 0;
        int mCnt = 0;
        bit dq, acc;
        logic [5:0]  expCtl;
        logic [31:0] expAddr, expStore, expIload, expDload;
        clear_inputs();
        @(posedge CLK);
        #1 nRST = 0;
        #1 nRST = 1;
        for (int c = 0; c < 400; c++) begin
            iREN = $urandom_range(0, 9) < 7;
            dREN = $urandom_range(0, 9) < 4;
            dWEN = $urandom_range(0, 9) < 3;
            iaddr = $urandom; daddr = $urandom; dstore = $urandom; ramload = $urandom;
            ramstate = 2'($urandom_range(0, 3));
            #1;
            dq = dREN || dWEN;
            acc = ramstate == 2'd2;
            expCtl = {mOwner == 1 || (mOwner == 2 && !dWEN), mOwner == 2 && dWEN,
                      !(mOwner == 1 && acc), !(mOwner == 2 && acc), 2'(mOwner)};
            expAddr  = mOwner == 1 ? iaddr : mOwner == 2 ? daddr : 32'h0;
            expStore = (mOwner == 2 && dWEN) ? dstore : 32'h0;
            expIload = mOwner == 1 ? ramload : 32'h0;
            expDload = mOwner == 2 ? ramload : 32'h0;
            checks++;
            if ({ramREN, ramWEN, iwait, dwait, owner} !== expCtl) begin
                errors++;
                $display("FAIL rand_ctl c%0d: got %b expected %b", c, {ramREN, ramWEN, iwait, dwait, owner}, expCtl);
            end
            checks++;
            if (ramaddr !== expAddr || ramstore !== expStore) begin
                errors++;
                $display("FAIL rand_bus c%0d: got %0h/%0h expected %0h/%0h", c, ramaddr, ramstore, expAddr, expStore);
            end
            checks++;
            if (iload !== expIload || dload !== expDload) begin
                errors++;
                $display("FAIL rand_load c%0d: got %0h/%0h expected %0h/%0h", c, iload, dload, expIload, expDload);
            end
            @(posedge CLK);
            if (mOwner == 0) begin
                if (dq && (!iREN || mCnt < 4)) begin
                    mOwner = 2;
                    mCnt = iREN ? (mCnt + 1 > 4 ? 4 : mCnt + 1) : 0;
                end else if (iREN) begin
                    mOwner = 1;
                    mCnt = 0;
                end
            end else if (mOwner == 1) begin
                if (acc || !iREN) mOwner = 0;
            end else if (acc || !dq) begin
                mOwner = 0;
            end
            #1;
        end
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_ifetch();
        test_simultaneous();
        test_starvation();
        test_write_priority();
        test_abort_error();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
